// File: rtl/seq_detect_fsm_pair.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_fsm_pair
// Description : Detector for runs of consecutive 1s on the serial input w.
//               A Moore FSM and a Mealy FSM run side by side so the
//               difference in output timing between the two styles can be
//               observed directly.
//                 - z_mealy rises in the same cycle as the RUN_LEN-th
//                   consecutive 1. It is combinational from w.
//                 - z_moore rises one clock later. It depends on state only.
//               Both flags stay high while w stays 1 (overlapping detect).
//
// Parameters  : RUN_LEN     number of consecutive 1s to detect (1..15)
//               SW          derived width of the state outputs
//
// Ports       : clk         rising-edge clock
//               Resetn      synchronous reset, active HIGH (name is historic)
//               w           serial data input, sampled on the rising edge
//               z_moore     Moore detect flag (registered state decode)
//               z_mealy     Mealy detect flag (combinational from w)
//               moore_state Moore state index, 0..RUN_LEN
//               mealy_state Mealy state index, 0..RUN_LEN-1
//
// Revision    : 1.0  initial release
// ============================================================================
module seq_detect_fsm_pair #(
    parameter  int RUN_LEN = 2,
    localparam int SW      = $clog2(RUN_LEN + 1)
) (
    input  logic          clk,
    input  logic          Resetn,
    input  logic          w,
    output logic          z_moore,
    output logic          z_mealy,
    output logic [SW-1:0] moore_state,
    output logic [SW-1:0] mealy_state
);

    // ------------------------------------------------------------------------
    // Reject illegal run lengths while the design is elaborated.
    // ------------------------------------------------------------------------
    generate
        if ((RUN_LEN < 1) || (RUN_LEN > 15)) begin : g_bad_run_len
            $error("seq_detect_fsm_pair: RUN_LEN must be in 1..15");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State encodings. State index k means "the last k samples were 1".
    // The Moore machine needs one extra state because its output can only
    // assert once the RUN_LEN-th 1 has already been stored in state.
    // ------------------------------------------------------------------------
    localparam logic [SW-1:0] c_S0         = '0;
    localparam logic [SW-1:0] c_ONE        = SW'(1);
    localparam logic [SW-1:0] c_MOORE_LAST = SW'(RUN_LEN);
    localparam logic [SW-1:0] c_MEALY_LAST = SW'(RUN_LEN - 1);

    logic [SW-1:0] r_moore_state;
    logic [SW-1:0] r_mealy_state;
    logic [SW-1:0] w_moore_next;
    logic [SW-1:0] w_mealy_next;

    // ------------------------------------------------------------------------
    // Moore next state: count 1s, saturate at S_RUN_LEN, any 0 returns to S0.
    // ------------------------------------------------------------------------
    always_comb begin
        w_moore_next = c_S0;
        if (w) begin
            if (r_moore_state == c_MOORE_LAST) begin
                w_moore_next = c_MOORE_LAST;
            end else begin
                w_moore_next = r_moore_state + c_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Mealy next state: same counting rule, but saturating one state earlier.
    // The detect is signalled on the transition out of the last state, so no
    // state for "RUN_LEN ones seen" is needed. With RUN_LEN=1 the machine has
    // a single state and the register stays at 0.
    // ------------------------------------------------------------------------
    always_comb begin
        w_mealy_next = c_S0;
        if (w) begin
            if (r_mealy_state == c_MEALY_LAST) begin
                w_mealy_next = c_MEALY_LAST;
            end else begin
                w_mealy_next = r_mealy_state + c_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers. Reset has priority over w and discards any partial run.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (Resetn) begin
            r_moore_state <= c_S0;
        end else begin
            r_moore_state <= w_moore_next;
        end
    end

    always_ff @(posedge clk) begin
        if (Resetn) begin
            r_mealy_state <= c_S0;
        end else begin
            r_mealy_state <= w_mealy_next;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. The Moore flag is a pure state decode. The Mealy flag is gated
    // by the reset input so it drops in the very cycle reset is applied, even
    // before the state register has been cleared.
    // ------------------------------------------------------------------------
    assign z_moore     = (r_moore_state == c_MOORE_LAST);
    assign z_mealy     = w & (r_mealy_state == c_MEALY_LAST) & ~Resetn;
    assign moore_state = r_moore_state;
    assign mealy_state = r_mealy_state;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_fsm_pair.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_fsm_pair
// Description : Scoreboard bench for seq_detect_fsm_pair. Three instances
//               (RUN_LEN = 1, 2, 4) share the same clock, reset and w. The
//               reference model only tracks how many consecutive 1s have been
//               sampled since the last reset and derives every expected
//               output from that count.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seq_detect_fsm_pair;

    localparam int c_NDUT = 3;

    typedef struct packed {
        logic       zme;
        logic       zmo;
        logic [3:0] ms;
        logic [3:0] mls;
    } one_t;

    typedef one_t [c_NDUT-1:0] exp_t;

    logic clk    = 1'b0;
    logic Resetn = 1'b1;
    logic w      = 1'b0;

    always #5 clk = ~clk;

    logic [c_NDUT-1:0] zme_a;
    logic [c_NDUT-1:0] zmo_a;
    logic [0:0]        ms_l1;
    logic [0:0]        mls_l1;
    logic [1:0]        ms_l2;
    logic [1:0]        mls_l2;
    logic [2:0]        ms_l4;
    logic [2:0]        mls_l4;

    seq_detect_fsm_pair #(.RUN_LEN(1)) u_dut_l1 (
        .clk(clk), .Resetn(Resetn), .w(w),
        .z_moore(zmo_a[0]), .z_mealy(zme_a[0]),
        .moore_state(ms_l1), .mealy_state(mls_l1)
    );

    seq_detect_fsm_pair #(.RUN_LEN(2)) u_dut_l2 (
        .clk(clk), .Resetn(Resetn), .w(w),
        .z_moore(zmo_a[1]), .z_mealy(zme_a[1]),
        .moore_state(ms_l2), .mealy_state(mls_l2)
    );

    seq_detect_fsm_pair #(.RUN_LEN(4)) u_dut_l4 (
        .clk(clk), .Resetn(Resetn), .w(w),
        .z_moore(zmo_a[2]), .z_mealy(zme_a[2]),
        .moore_state(ms_l4), .mealy_state(mls_l4)
    );

    logic [3:0] act_ms  [c_NDUT];
    logic [3:0] act_mls [c_NDUT];

    assign act_ms[0]  = {3'b000, ms_l1};
    assign act_ms[1]  = {2'b00,  ms_l2};
    assign act_ms[2]  = {1'b0,   ms_l4};
    assign act_mls[0] = {3'b000, mls_l1};
    assign act_mls[1] = {2'b00,  mls_l2};
    assign act_mls[2] = {1'b0,   mls_l4};

    // ------------------------------------------------------------------------
    // Reference model: consecutive-1 count since the last reset edge.
    // ------------------------------------------------------------------------
    int   run    = 0;
    bit   valid  = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    event ev_push;

    function automatic int len_of(int i);
        case (i)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int min2(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic one_t model(int l, bit rst_v, bit w_v);
        one_t m;
        m.zme = !rst_v && w_v && ((run + 1) >= l);
        m.zmo = (run >= l);
        m.ms  = 4'(min2(run, l));
        m.mls = 4'(min2(run, l - 1));
        return m;
    endfunction

    task automatic push_exp();
        exp_t e;
        if (valid) begin
            for (int i = 0; i < c_NDUT; i++) begin
                e[i] = model(len_of(i), Resetn, w);
            end
            q.push_back(e);
            ->ev_push;
        end
    endtask

    task automatic model_edge(bit r, bit wv);
        if (r) begin
            run   = 0;
            valid = 1'b1;
        end else if (wv) begin
            if (run < 100) run = run + 1;
        end else begin
            run = 0;
        end
    endtask

    // One clock cycle with constant inputs.
    task automatic cyc(bit r, bit wv);
        @(negedge clk);
        Resetn = r;
        w      = wv;
        push_exp();
        @(posedge clk);
        model_edge(r, wv);
    endtask

    // One clock cycle where w changes between edges; only the second value
    // is sampled.
    task automatic tog(bit w1, bit w2);
        @(negedge clk);
        Resetn = 1'b0;
        w      = w1;
        push_exp();
        #2;
        w = w2;
        push_exp();
        @(posedge clk);
        model_edge(1'b0, w2);
    endtask

    task automatic chk(string nm, logic [7:0] a, logic [7:0] ex);
        checks++;
        if (a !== ex) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, a, ex);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: every push marks a point where the DUT outputs are defined.
    // ------------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(ev_push);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                for (int i = 0; i < c_NDUT; i++) begin
                    chk($sformatf("z_mealy_L%0d", len_of(i)), 8'(zme_a[i]), 8'(e[i].zme));
                    chk($sformatf("z_moore_L%0d", len_of(i)), 8'(zmo_a[i]), 8'(e[i].zmo));
                    chk($sformatf("moore_state_L%0d", len_of(i)), 8'(act_ms[i]), 8'(e[i].ms));
                    chk($sformatf("mealy_state_L%0d", len_of(i)), 8'(act_mls[i]), 8'(e[i].mls));
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus.
    // ------------------------------------------------------------------------
    initial begin
        logic [11:0] basic;
        bit          r_v;
        bit          w_v;
        basic = 12'b1011_0011_1011;

        // Reset held for two cycles with w=1.
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);

        // Basic sequence 1,0,1,1,0,0,1,1,1,0,1,1.
        for (int i = 11; i >= 0; i--) cyc(1'b0, basic[i]);

        // Long run of six 1s.
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);

        // Reset in the middle of a run.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1);

        // Mealy output follows w between edges.
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        tog(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        tog(1'b0, 1'b1);
        tog(1'b1, 1'b1);

        // Randomised traffic with occasional resets and mid-cycle toggles.
        for (int i = 0; i < 600; i++) begin
            r_v = ($urandom_range(0, 24) == 0);
            w_v = ($urandom_range(0, 9) < 7);
            if (!r_v && ($urandom_range(0, 9) == 0)) begin
                tog(1'($urandom_range(0, 1)), w_v);
            end else begin
                cyc(r_v, w_v);
            end
        end

        #20;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
